// File: rtl/rgb_pwm_pkg.sv
// Shared constants and helpers for the multi-LED RGB PWM controller.
package rgb_pwm_pkg;

    localparam logic MODE_STATIC  = 1'b0;
    localparam logic MODE_BREATHE = 1'b1;

    localparam int COL_R   = 0;
    localparam int COL_G   = 1;
    localparam int COL_B   = 2;
    localparam int NUM_COL = 3;

    // Per-LED pin order is {B,G,R}, red in the LSB.
    function automatic logic [2:0] pack_led(input logic r, input logic g, input logic b);
        return {b, g, r};
    endfunction

endpackage

// File: rtl/rgb_pwm_array_if.sv
// Duty/mode write port from the board control logic into the PWM array.
interface rgb_pwm_array_if #(
    parameter int ADDR_W   = 4,
    parameter int PWM_BITS = 8
);
    logic                  WR_EN;
    logic [ADDR_W-1:0]     WR_ADDR;
    logic [3*PWM_BITS-1:0] WR_DATA;
    logic                  WR_MODE;

    modport master (output WR_EN, output WR_ADDR, output WR_DATA, output WR_MODE);
    modport slave  (input  WR_EN, input  WR_ADDR, input  WR_DATA, input  WR_MODE);
endinterface

// File: rtl/rgb_pwm_led.sv
// One RGB LED channel: shadow/active duty, breathe level, compare and output register.
module rgb_pwm_led
    import rgb_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PWM_BITS-1:0]   cnt,
    input  logic                  period_end,
    input  logic                  we,
    input  logic [3*PWM_BITS-1:0] wr_data,
    input  logic                  wr_mode,
    output logic [2:0]            led
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = {PWM_BITS{1'b1}};

    logic [3*PWM_BITS-1:0] shadow_duty_q, shadow_duty_d;
    logic [3*PWM_BITS-1:0] active_duty_q, active_duty_d;
    logic                  shadow_mode_q, shadow_mode_d;
    logic                  active_mode_q, active_mode_d;
    logic [PWM_BITS-1:0]   lvl_q, lvl_d;
    logic                  dir_q, dir_d;
    logic [2:0]            led_q, led_d;

    logic [PWM_BITS-1:0]   lvl_step;
    logic [PWM_BITS-1:0]   duty_c [NUM_COL];
    logic [2*PWM_BITS-1:0] prod   [NUM_COL];
    logic [PWM_BITS-1:0]   eff    [NUM_COL];
    logic [NUM_COL-1:0]    raw;

    // The breathe step follows the mode being made active at this boundary,
    // so a fresh breathe write starts at level 1 in its first period.
    always_comb begin : regs_next
        shadow_duty_d = shadow_duty_q;
        shadow_mode_d = shadow_mode_q;
        active_duty_d = active_duty_q;
        active_mode_d = active_mode_q;
        lvl_d         = lvl_q;
        dir_d         = dir_q;
        lvl_step      = dir_q ? (lvl_q - PWM_BITS'(1)) : (lvl_q + PWM_BITS'(1));

        if (we) begin
            shadow_duty_d = wr_data;
            shadow_mode_d = wr_mode;
        end

        if (period_end) begin
            active_duty_d = shadow_duty_q;
            active_mode_d = shadow_mode_q;
            if (shadow_mode_q == MODE_BREATHE) begin
                lvl_d = lvl_step;
                if (lvl_step == LVL_MAX) begin
                    dir_d = 1'b1;
                end else if (lvl_step == '0) begin
                    dir_d = 1'b0;
                end
            end
        end
    end

    always_comb begin : duty_eval
        raw = '0;
        for (int c = 0; c < NUM_COL; c++) begin
            duty_c[c] = active_duty_q[c*PWM_BITS +: PWM_BITS];
            prod[c]   = {{PWM_BITS{1'b0}}, duty_c[c]} * {{PWM_BITS{1'b0}}, lvl_q};
            eff[c]    = (active_mode_q == MODE_BREATHE) ? PWM_BITS'(prod[c] >> PWM_BITS)
                                                        : duty_c[c];
            raw[c]    = (cnt < eff[c]);
        end
        led_d = pack_led(raw[COL_R], raw[COL_G], raw[COL_B]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_duty_q <= '0;
            shadow_mode_q <= MODE_STATIC;
            active_duty_q <= '0;
            active_mode_q <= MODE_STATIC;
            lvl_q         <= '0;
            dir_q         <= 1'b0;
            led_q         <= '0;
        end else begin
            shadow_duty_q <= shadow_duty_d;
            shadow_mode_q <= shadow_mode_d;
            active_duty_q <= active_duty_d;
            active_mode_q <= active_mode_d;
            lvl_q         <= lvl_d;
            dir_q         <= dir_d;
            led_q         <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/rgb_pwm_array.sv
// NUM_LEDS-channel RGB PWM: shared prescaler and period counter feeding
// per-LED double-buffered duty channels.
module rgb_pwm_array
    import rgb_pwm_pkg::*;
#(
    parameter int NUM_LEDS = 2,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 4,
    parameter int ADDR_W   = 4
)
(
    input  logic                  CLK,
    input  logic                  RST,
    rgb_pwm_array_if.slave        wr,
    output logic [3*NUM_LEDS-1:0] LED,
    output logic                  PERIOD_END
);

    localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                period_end_q, period_end_d;
    logic                tick;
    logic                period_end;
    logic [NUM_LEDS-1:0] we_led;

    // With PRESCALE=1 the prescaler stays at 0 and tick is permanently high.
    always_comb begin : timebase_next
        tick         = (pre_q == PRE_LAST);
        pre_d        = tick ? '0 : (pre_q + PRE_W'(1));
        cnt_d        = tick ? (cnt_q + PWM_BITS'(1)) : cnt_q;
        period_end   = tick && (cnt_q == {PWM_BITS{1'b1}});
        period_end_d = period_end;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_q        <= '0;
            cnt_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            cnt_q        <= cnt_d;
            period_end_q <= period_end_d;
        end
    end

    assign PERIOD_END = period_end_q;

    // Out-of-range addresses match no channel and are dropped.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_led
        assign we_led[i] = wr.WR_EN && (wr.WR_ADDR == ADDR_W'(i));

        rgb_pwm_led #(
            .PWM_BITS (PWM_BITS)
        ) u_led (
            .clk        (CLK),
            .rst        (RST),
            .cnt        (cnt_q),
            .period_end (period_end),
            .we         (we_led[i]),
            .wr_data    (wr.WR_DATA),
            .wr_mode    (wr.WR_MODE),
            .led        (LED[3*i +: 3])
        );
    end

endmodule
